// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes,
// the default lock burst length and the lock state encoding.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LOCK_MAX_DEF = 8;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/dm_lane.sv
// Lane steering for one memory access: word-aligns the address, replicates
// store data across byte lanes, builds byte enables and flags misalignment.
// A misaligned access, a load or an invalid slot leaves the port write-idle.
module dm_lane (
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  byteen_o,
    output logic        err_o
);
    import dm_pkg::*;

    logic [1:0] ofs;
    logic       mis;
    logic [31:0] lane_wd;
    logic [3:0]  lane_be;

    assign ofs = addr_i[1:0];

    // Decode size and offset into lane data, enables and misalignment.
    always_comb begin
        mis     = 1'b0;
        lane_wd = '0;
        lane_be = '0;
        case (size_i)
            SZ_B: begin
                lane_wd = {4{wdata_i[7:0]}};
                lane_be = 4'b0001 << ofs;
            end
            SZ_H: begin
                mis     = ofs[0];
                lane_wd = {2{wdata_i[15:0]}};
                lane_be = 4'b0011 << ofs;
            end
            SZ_W: begin
                mis     = (ofs != 2'b00);
                lane_wd = wdata_i;
                lane_be = 4'b1111;
            end
            default: mis = 1'b1;
        endcase
    end

    // Drive the port only for a valid, aligned access; writes only for stores.
    always_comb begin
        addr_o   = '0;
        wdata_o  = '0;
        byteen_o = '0;
        err_o    = 1'b0;
        if (valid_i) begin
            addr_o = {addr_i[31:2], 2'b00};
            err_o  = mis;
            if (we_i && !mis) begin
                wdata_o  = lane_wd;
                byteen_o = lane_be;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single data-memory port. Requester 0 is the
// CPU M-stage, requester 1 a secondary master that may lock the bus for a
// bounded burst. Grants are combinational; only fairness and lock state are
// registered.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [1:0]        r0_size,
    input  logic [1:0]        r1_size,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [31:0]       r1_wdata,
    input  logic              r1_lock,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_err,
    output logic              r1_err,
    output logic [31:0]       rd_word,
    output logic [31:0]       m_data_addr,
    output logic [31:0]       m_data_wdata,
    output logic [3:0]        m_data_byteen,
    input  logic [31:0]       m_data_rdata
);

    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    lock_state_e      lock_state_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic             last_q;

    logic              gnt0;
    logic              gnt1;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              lane_err;

    // Grant selection: lock holds requester 1 until its budget is spent,
    // otherwise round-robin against the last winner. Nothing during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (r0_req && !r1_req) begin
                gnt0 = 1'b1;
            end else if (r1_req && !r0_req) begin
                gnt1 = 1'b1;
            end else if (r0_req && r1_req) begin
                if (lock_state_q == LK_LOCKED && lock_cnt_q < CNT_MAX) begin
                    gnt1 = 1'b1;
                end else if (last_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    // Route the winning request to the single lane-steering instance.
    always_comb begin
        sel_we    = r0_we;
        sel_size  = r0_size;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        if (gnt1) begin
            sel_we    = r1_we;
            sel_size  = r1_size;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
    end

    dm_lane u_lane (
        .valid_i  (gnt0 | gnt1),
        .we_i     (sel_we),
        .size_i   (sel_size),
        .addr_i   (32'(sel_addr)),
        .wdata_i  (sel_wdata),
        .addr_o   (m_data_addr),
        .wdata_o  (m_data_wdata),
        .byteen_o (m_data_byteen),
        .err_o    (lane_err)
    );

    assign r0_gnt  = gnt0;
    assign r1_gnt  = gnt1;
    assign r0_err  = gnt0 & lane_err;
    assign r1_err  = gnt1 & lane_err;
    assign rd_word = m_data_rdata;

    // Fairness pointer and lock FSM; a lock drops on any non-locked r1 grant,
    // on a forced r0 grant, or when requester 1 stops requesting.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_q <= LK_UNLOCKED;
            lock_cnt_q   <= '0;
            last_q       <= 1'b1;
        end else begin
            if (gnt0) begin
                last_q <= 1'b0;
            end else if (gnt1) begin
                last_q <= 1'b1;
            end
            case (lock_state_q)
                LK_UNLOCKED: begin
                    if (gnt1 && r1_lock) begin
                        lock_state_q <= LK_LOCKED;
                        lock_cnt_q   <= CNT_W'(1);
                    end
                end
                LK_LOCKED: begin
                    if (gnt1 && r1_lock) begin
                        if (lock_cnt_q != CNT_MAX) begin
                            lock_cnt_q <= lock_cnt_q + CNT_W'(1);
                        end
                    end else if (gnt1 || gnt0 || !r1_req) begin
                        lock_state_q <= LK_UNLOCKED;
                        lock_cnt_q   <= '0;
                    end
                end
                default: begin
                    lock_state_q <= LK_UNLOCKED;
                    lock_cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a small word memory answers the port,
// each cycle pushes its expected outcome to a scoreboard, which is popped and
// compared on the falling edge.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r1_req, r0_we, r1_we, r1_lock;
    logic [1:0]  r0_size, r1_size;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_err, r1_err;
    logic [31:0] rd_word, m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(32), .LOCK_MAX(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .r0_req        (r0_req),
        .r1_req        (r1_req),
        .r0_we         (r0_we),
        .r1_we         (r1_we),
        .r0_size       (r0_size),
        .r1_size       (r1_size),
        .r0_addr       (r0_addr),
        .r1_addr       (r1_addr),
        .r0_wdata      (r0_wdata),
        .r1_wdata      (r1_wdata),
        .r1_lock       (r1_lock),
        .r0_gnt        (r0_gnt),
        .r1_gnt        (r1_gnt),
        .r0_err        (r0_err),
        .r1_err        (r1_err),
        .rd_word       (rd_word),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata)
    );

    // Memory: combinational read, byte-enabled write on the rising edge.
    logic [31:0] mem [0:63] = '{default: 32'h0};
    assign m_data_rdata = mem[m_data_addr[7:2]];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (m_data_byteen[i]) mem[m_data_addr[7:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
    end

    typedef struct {
        string       tag;
        logic        g0, g1, err;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_wd;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Push expectation, then compare against the DUT mid-cycle.
    task automatic cyc(input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
            x = sb.pop_front();
            chk({x.tag, ".r0_gnt"}, 32'(r0_gnt), 32'(x.g0));
            chk({x.tag, ".r1_gnt"}, 32'(r1_gnt), 32'(x.g1));
            chk({x.tag, ".err"}, 32'((r0_gnt & r0_err) | (r1_gnt & r1_err)), 32'(x.err));
            chk({x.tag, ".byteen"}, 32'(m_data_byteen), 32'(x.be));
            if (x.chk_addr) chk({x.tag, ".addr"}, m_data_addr, x.addr);
            if (x.chk_wd)   chk({x.tag, ".wdata"}, m_data_wdata, x.wd);
            if (x.chk_rd)   chk({x.tag, ".rd_word"}, rd_word, x.rd);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input string tag, input logic g0, input logic g1, input logic err);
        exp_t e;
        e.tag = tag; e.g0 = g0; e.g1 = g1; e.err = err;
        e.chk_addr = 1'b0; e.addr = '0; e.chk_wd = 1'b0; e.wd = '0;
        e.be = 4'b0000; e.chk_rd = 1'b0; e.rd = '0;
        return e;
    endfunction

    task automatic idle(input string tag);
        exp_t e = mk(tag, 1'b0, 1'b0, 1'b0);
        e.chk_addr = 1'b1; e.chk_wd = 1'b1;
        cyc(e);
    endtask

    task automatic ld(input string tag, input logic g0, input logic g1, input logic [31:0] a,
                      input logic crd, input logic [31:0] rd);
        exp_t e = mk(tag, g0, g1, 1'b0);
        e.chk_addr = 1'b1; e.addr = a; e.chk_rd = crd; e.rd = rd;
        cyc(e);
    endtask

    task automatic st(input string tag, input logic g0, input logic g1, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
        exp_t e = mk(tag, g0, g1, 1'b0);
        e.chk_addr = 1'b1; e.addr = a; e.chk_wd = 1'b1; e.wd = wd; e.be = be;
        cyc(e);
    endtask

    task automatic er(input string tag, input logic g0, input logic g1);
        cyc(mk(tag, g0, g1, 1'b1));
    endtask

    task automatic set_r0(input logic req, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        r0_req = req; r0_we = we; r0_size = sz; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input logic lk);
        r1_req = req; r1_we = we; r1_size = sz; r1_addr = a; r1_wdata = d; r1_lock = lk;
    endtask

    initial begin
        reset = 1'b1;
        set_r0(1, 0, 2'd2, 32'h10, 32'h0);
        set_r1(1, 0, 2'd2, 32'h20, 32'h0, 1'b1);
        #1;
        idle("rst0");
        idle("rst1");
        reset = 1'b0;
        r1_lock = 1'b0;

        // Round-robin on word loads
        ld("rr_a", 1, 0, 32'h10, 1, 32'h0);
        set_r0(1, 0, 2'd2, 32'h14, 32'h0);
        ld("rr_b", 0, 1, 32'h20, 0, 32'h0);
        r1_req = 1'b0;
        ld("rr_c", 1, 0, 32'h14, 0, 32'h0);

        // Byte store and readback
        set_r0(1, 1, 2'd0, 32'h13, 32'h0000_00AB);
        st("sb13", 1, 0, 32'h10, 32'hABAB_ABAB, 4'b1000);
        set_r0(1, 0, 2'd2, 32'h10, 32'h0);
        ld("lw10", 1, 0, 32'h10, 1, 32'hAB00_0000);

        // Half store, misaligned accesses leave memory alone
        r0_req = 1'b0;
        set_r1(1, 1, 2'd1, 32'h22, 32'h0000_1234, 1'b0);
        st("sh22", 0, 1, 32'h20, 32'h1234_1234, 4'b1100);
        r1_req = 1'b0;
        set_r0(1, 1, 2'd1, 32'h21, 32'h0000_BEEF);
        er("sh21_mis", 1, 0);
        set_r0(1, 0, 2'd2, 32'h20, 32'h0);
        ld("lw20", 1, 0, 32'h20, 1, 32'h1234_0000);
        r0_req = 1'b0;
        set_r1(1, 1, 2'd3, 32'h24, 32'hFFFF_FFFF, 1'b0);
        er("sz3", 0, 1);
        r1_req = 1'b0;
        set_r0(1, 1, 2'd2, 32'h12, 32'hFFFF_FFFF);
        er("sw12_mis", 1, 0);
        set_r0(1, 1, 2'd0, 32'h25, 32'h0000_005A);
        st("sb25", 1, 0, 32'h24, 32'h5A5A_5A5A, 4'b0010);
        set_r0(1, 1, 2'd1, 32'h26, 32'h0000_CAFE);
        st("sh26", 1, 0, 32'h24, 32'hCAFE_CAFE, 4'b1100);
        set_r0(1, 0, 2'd2, 32'h24, 32'h0);
        ld("lw24", 1, 0, 32'h24, 1, 32'hCAFE_5A00);

        // Lock burst: 8 r1 grants, then r0 forced in, then alternation
        set_r0(1, 0, 2'd2, 32'h10, 32'h0);
        set_r1(1, 0, 2'd2, 32'h20, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) ld($sformatf("lk_r1_%0d", i), 0, 1, 32'h20, 0, 32'h0);
        ld("lk_r0", 1, 0, 32'h10, 0, 32'h0);
        r1_lock = 1'b0;
        ld("alt1", 0, 1, 32'h20, 0, 32'h0);
        ld("alt2", 1, 0, 32'h10, 0, 32'h0);
        ld("alt3", 0, 1, 32'h20, 0, 32'h0);
        ld("alt4", 1, 0, 32'h10, 0, 32'h0);

        // Reset on the third locked beat
        r1_lock = 1'b1;
        ld("rb1", 0, 1, 32'h20, 0, 32'h0);
        ld("rb2", 0, 1, 32'h20, 0, 32'h0);
        reset = 1'b1;
        idle("rb3_rst");
        reset = 1'b0;
        ld("rb_post0", 1, 0, 32'h10, 0, 32'h0);
        r1_lock = 1'b0;
        ld("rb_post1", 0, 1, 32'h20, 0, 32'h0);

        // Lone requester 1 without lock
        r0_req = 1'b0;
        for (int i = 0; i < 5; i++) ld($sformatf("solo_r1_%0d", i), 0, 1, 32'h20, 0, 32'h0);

        r1_req = 1'b0;
        idle("end_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter sharing the single data-memory port (`m_data_*`) between the CPU M-stage (requester 0) and a secondary master such as DMA or a debug loader (requester 1). Each granted access completes in one cycle, which matches the memory model: reads are combinational and writes commit on `posedge clk`. The block applies round-robin fairness and supports an optional bus lock for requester 1 bursts. It also converts size and address into lane-shifted write data and `m_data_byteen`, and flags misaligned accesses without touching memory.

## Interface
- `ADDR_W`, default 32: address width.
- `LOCK_MAX`, default 8: maximum consecutive grants to requester 1 under lock before requester 0 is forced in.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `r0_req`, `r1_req`  in  1 each  access request; held stable until the matching `gnt`.
- `r0_we`, `r1_we`  in  1 each  1 = store, 0 = load.
- `r0_size`, `r1_size`  in  2 each  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- `r0_addr`, `r1_addr`  in  ADDR_W each  byte address.
- `r0_wdata`, `r1_wdata`  in  32 each  store data, right-aligned.
- `r1_lock`  in  1  requester 1 burst lock; sampled only on an `r1_gnt` cycle.
- `r0_gnt`, `r1_gnt`  out  1 each  access performed or errored this cycle.
- `r0_err`, `r1_err`  out  1 each  misaligned; valid only with the matching `gnt`.
- `rd_word`  out  32  `m_data_rdata` passthrough, shared by both requesters.
- `m_data_addr`  out  32  word-aligned address; low 2 bits are 0.
- `m_data_wdata`  out  32  lane-shifted store data.
- `m_data_byteen`  out  4  byte write enables; 0 for loads and errors.
- `m_data_rdata`  in  32  memory read word.

## Operation
- State registers:
  - `last`: last granted requester; resets to 1.
  - `locked`: lock flag; resets to 0.
  - `lock_cnt`: 0..LOCK_MAX; resets to 0.
- Grant rule, combinational in the same cycle:
  - No grant while `reset` is high.
  - If exactly one request is present, grant it.
  - If both are present and `locked=1` with `lock_cnt<LOCK_MAX`, grant requester 1.
  - Otherwise grant requester `~last`.
- At most one `gnt` is high per cycle.
- Misalignment: half access with `addr[0]=1`, word access with `addr[1:0]!=0`, or size 3. The access is granted with `err=1`, and the memory port is idle (`byteen=0`).
- Lane generation, with o = `addr[1:0]`:
  - Byte: `byteen = 1<<o`, `wdata` replicated to all 4 lanes.
  - Half: `byteen = 4'b0011<<o`, `wdata[15:0]` replicated to both halves.
  - Word: `byteen = 4'b1111`, `wdata` passed unchanged.
- Loads: `byteen=0`. `m_data_addr` = granted addr & ~3.
- With no grant, `m_data_addr=0`, `m_data_wdata=0`, `byteen=0`.
- Lock FSM:
  - UNLOCKED → LOCKED on `r1_gnt & r1_lock`; `lock_cnt` ← 1.
  - LOCKED, `r1_gnt & r1_lock`: `lock_cnt` ← `lock_cnt+1`, saturating at LOCK_MAX.
  - LOCKED, `r1_gnt & ~r1_lock`: → UNLOCKED, `lock_cnt` ← 0.
  - LOCKED, `r0_gnt` (which occurs only once LOCK_MAX is reached): → UNLOCKED, `lock_cnt` ← 0.
  - LOCKED with `r1_req=0`: the lock drops → UNLOCKED.
- `last` updates to the granted index on every grant, errored grants included.

## Timing
- Grant, lanes and `rd_word` are combinational: zero-cycle latency. Store data commits at the next `posedge`.
- A requester samples `rd_word` in its `gnt` cycle. The losing requester holds its request.
- Worst-case wait for requester 0 is LOCK_MAX cycles. Worst-case wait for requester 1 is 1 cycle.
- Reset asserted mid-burst: from the next edge `locked=0`, `lock_cnt=0`, `last=1`. Outputs are idle in every cycle where `reset=1`.
- Simultaneous request and lock release: the grant in that cycle follows the pre-edge state.

## Structure
- Shared package `dm_pkg`:
  - Size encodings: `SZ_B=0`, `SZ_H=1`, `SZ_W=2`.
  - `LOCK_MAX` default.
- Sub-module `dm_lane`: pure combinational size/addr/wdata → {aligned addr, wdata, byteen, err}. Instantiated once, on the mux-selected request.
- Top holds the arbiter, the lock FSM and the muxes. Expected size is about 180 lines.

## Test plan
- Reset, then both requesters issue a word load to 0x10 and 0x20 → cycle 1 `r0_gnt`, `m_data_addr=0x10`; cycle 2 `r1_gnt`, `m_data_addr=0x20`.
- `r0` stores byte 0xAB to 0x13 → `byteen=4'b1000`, `wdata=0xABABABAB`. Then a word load from 0x10 returns 0xAB000000.
- `r1` stores half 0x1234 to 0x22 → `byteen=4'b1100`. `r0` stores half to 0x21 → `r0_gnt=1`, `r0_err=1`, `byteen=0`, memory unchanged.
- `r1_lock` held with both requesting continuously, LOCK_MAX=8 → 8 consecutive `r1_gnt`, then `r0_gnt`, then alternation resumes.
- Reset asserted on the 3rd locked beat → all outputs 0 that cycle. After release with both requesting, `r0` is granted first.
- Only `r1` requests for 5 cycles with no lock → `r1_gnt` every cycle, never `r0_gnt`.
